// File: rtl/adc_acquisition_scheduler.sv
// Sequences the four 8-bit acquisition paths (R2R/PWM, regular/successive) and
// publishes one tagged sample per conversion with a one-cycle valid strobe.
module adc_acquisition_scheduler #(
  parameter int unsigned SETTLE_CYCLES  = 16,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_auto_mode,
  input  logic [1:0] i_manual_mode,
  input  logic [3:0] i_mode_enable,
  input  logic [7:0] i_r2r_raw,
  input  logic [7:0] i_r2r_sar_value,
  input  logic       i_r2r_sar_done,
  input  logic [7:0] i_pwm_raw,
  input  logic [7:0] i_pwm_sar_value,
  input  logic       i_pwm_sar_done,
  output logic       o_r2r_sar_start,
  output logic       o_pwm_sar_start,
  output logic [1:0] o_active_mode,
  output logic       o_busy,
  output logic [7:0] o_sample_out,
  output logic [1:0] o_sample_mode,
  output logic       o_sample_valid,
  output logic       o_timeout_err
);

  localparam int unsigned SCW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int unsigned TCW = $clog2(TIMEOUT_CYCLES);
  localparam logic [SCW-1:0] SETTLE_LAST  = SCW'(SETTLE_CYCLES - 1);
  localparam logic [TCW-1:0] TIMEOUT_LAST = TCW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    StIdle, StSelect, StSettle, StStart, StWaitDone, StCapture
  } state_e;

  state_e         r_state, w_state_next;
  logic [1:0]     r_last_mode, r_active_mode, r_sample_mode;
  logic [SCW-1:0] r_settle_cnt;
  logic [TCW-1:0] r_to_cnt;
  logic [7:0]     r_sar_value, r_sample_out;
  logic           r_r2r_start, r_pwm_start, r_busy, r_sample_valid, r_timeout_err;

  logic [1:0]     w_pick, w_cand;
  logic           w_pick_ok, w_done, w_timeout;
  logic [7:0]     w_capture_value;

  // Auto search walks last+4 down to last+1 so the nearest enabled code wins.
  always_comb begin
    w_pick    = r_last_mode;
    w_pick_ok = 1'b0;
    w_cand    = r_last_mode;
    if (i_auto_mode) begin
      for (int i = 4; i >= 1; i--) begin
        w_cand = r_last_mode + 2'(i);
        if (i_mode_enable[w_cand]) begin
          w_pick    = w_cand;
          w_pick_ok = 1'b1;
        end
      end
    end else begin
      w_pick    = i_manual_mode;
      w_pick_ok = i_mode_enable[i_manual_mode];
    end
  end

  assign w_done          = r_active_mode[1] ? i_pwm_sar_done : i_r2r_sar_done;
  assign w_capture_value = r_active_mode[0] ? r_sar_value :
                           (r_active_mode[1] ? i_pwm_raw : i_r2r_raw);

  always_comb begin
    w_state_next = r_state;
    w_timeout    = 1'b0;
    unique case (r_state)
      StIdle:     if (i_mode_enable != 4'b0000) w_state_next = StSelect;
      StSelect: begin
        if (!w_pick_ok)     w_state_next = StIdle;
        else if (w_pick[0]) w_state_next = StStart;
        else                w_state_next = StSettle;
      end
      StSettle:   if (r_settle_cnt == SETTLE_LAST) w_state_next = StCapture;
      StStart:    w_state_next = StWaitDone;
      StWaitDone: begin
        // A done on the final timeout cycle still wins.
        if (w_done) begin
          w_state_next = StCapture;
        end else if (r_to_cnt == TIMEOUT_LAST) begin
          w_state_next = StIdle;
          w_timeout    = 1'b1;
        end
      end
      StCapture:  w_state_next = StIdle;
      default:    w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state        <= StIdle;
      r_last_mode    <= 2'd3;
      r_active_mode  <= 2'd0;
      r_settle_cnt   <= '0;
      r_to_cnt       <= '0;
      r_sar_value    <= 8'h00;
      r_sample_out   <= 8'h00;
      r_sample_mode  <= 2'd0;
      r_r2r_start    <= 1'b0;
      r_pwm_start    <= 1'b0;
      r_busy         <= 1'b0;
      r_sample_valid <= 1'b0;
      r_timeout_err  <= 1'b0;
    end else begin
      r_state        <= w_state_next;
      r_busy         <= (w_state_next != StIdle);
      r_r2r_start    <= (r_state == StSelect) && w_pick_ok && (w_pick == 2'd1);
      r_pwm_start    <= (r_state == StSelect) && w_pick_ok && (w_pick == 2'd3);
      r_sample_valid <= (r_state == StCapture);
      r_timeout_err  <= w_timeout;
      r_settle_cnt   <= (r_state == StSettle) ? r_settle_cnt + SCW'(1) : '0;
      r_to_cnt       <= (r_state == StWaitDone) ? r_to_cnt + TCW'(1) : '0;
      if ((r_state == StSelect) && w_pick_ok) begin
        r_active_mode <= w_pick;
        r_last_mode   <= w_pick;
      end
      if ((r_state == StWaitDone) && w_done) begin
        r_sar_value <= r_active_mode[1] ? i_pwm_sar_value : i_r2r_sar_value;
      end
      if (r_state == StCapture) begin
        r_sample_out  <= w_capture_value;
        r_sample_mode <= r_active_mode;
      end
    end
  end

  assign o_r2r_sar_start = r_r2r_start;
  assign o_pwm_sar_start = r_pwm_start;
  assign o_active_mode   = r_active_mode;
  assign o_busy          = r_busy;
  assign o_sample_out    = r_sample_out;
  assign o_sample_mode   = r_sample_mode;
  assign o_sample_valid  = r_sample_valid;
  assign o_timeout_err   = r_timeout_err;

endmodule

// File: tb/tb_adc_acquisition_scheduler.sv
// Bench for adc_acquisition_scheduler: timeline model compared every cycle plus
// directed scenarios with literal cycle/value expectations.
module tb_adc_acquisition_scheduler;

  localparam int unsigned S = 16;
  localparam int unsigned T = 10;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       auto_mode = 1'b1;
  logic [1:0] manual_mode = 2'd0;
  logic [3:0] mode_enable = 4'b0000;
  logic [7:0] r2r_raw = 8'h00, r2r_sar_value = 8'h00, pwm_raw = 8'h00, pwm_sar_value = 8'h00;
  logic       r2r_sar_done = 1'b0, pwm_sar_done = 1'b0;

  logic       r2r_sar_start, pwm_sar_start, busy, sample_valid, timeout_err;
  logic [1:0] active_mode, sample_mode;
  logic [7:0] sample_out;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit live = 1'b0;

  always #5 clk = ~clk;

  adc_acquisition_scheduler #(
    .SETTLE_CYCLES (S),
    .TIMEOUT_CYCLES(T)
  ) u_dut (
    .i_clk          (clk),
    .i_reset        (reset),
    .i_auto_mode    (auto_mode),
    .i_manual_mode  (manual_mode),
    .i_mode_enable  (mode_enable),
    .i_r2r_raw      (r2r_raw),
    .i_r2r_sar_value(r2r_sar_value),
    .i_r2r_sar_done (r2r_sar_done),
    .i_pwm_raw      (pwm_raw),
    .i_pwm_sar_value(pwm_sar_value),
    .i_pwm_sar_done (pwm_sar_done),
    .o_r2r_sar_start(r2r_sar_start),
    .o_pwm_sar_start(pwm_sar_start),
    .o_active_mode  (active_mode),
    .o_busy         (busy),
    .o_sample_out   (sample_out),
    .o_sample_mode  (sample_mode),
    .o_sample_valid (sample_valid),
    .o_timeout_err  (timeout_err)
  );

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
    end
  endtask

  task automatic chki(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Timeline model: m_cyc is the cycle index within the current transaction
  // (0 = idle cycle). Expected outputs describe the cycle after each edge.
  int         m_cyc, m_last, m_path, m_pick;
  bit         m_got;
  logic [7:0] m_val;
  logic       e_busy, e_r2r_start, e_pwm_start, e_valid, e_err;
  logic [1:0] e_active, e_mode;
  logic [7:0] e_out;

  always @(posedge clk) begin
    if (reset) begin
      live = 1'b1;
      cyc = 0;
      m_cyc = 0;
      m_last = 3;
      m_path = 0;
      m_got = 1'b0;
      m_val = 8'h00;
      e_busy = 1'b0; e_r2r_start = 1'b0; e_pwm_start = 1'b0;
      e_valid = 1'b0; e_err = 1'b0; e_active = 2'd0; e_mode = 2'd0; e_out = 8'h00;
    end else begin
      cyc = cyc + 1;
      e_valid = 1'b0; e_err = 1'b0; e_r2r_start = 1'b0; e_pwm_start = 1'b0;
      if (m_cyc == 0) begin
        if (mode_enable != 4'b0000) m_cyc = 1;
      end else if (m_cyc == 1) begin
        m_pick = -1;
        if (auto_mode) begin
          for (int i = 1; i <= 4; i++)
            if (m_pick < 0 && mode_enable[(m_last + i) % 4]) m_pick = (m_last + i) % 4;
        end else if (mode_enable[manual_mode]) begin
          m_pick = int'(manual_mode);
        end
        if (m_pick < 0) begin
          m_cyc = 0;
        end else begin
          m_last = m_pick;
          m_path = m_pick;
          e_active = 2'(m_pick);
          m_got = 1'b0;
          m_cyc = 2;
          e_r2r_start = (m_pick == 1);
          e_pwm_start = (m_pick == 3);
        end
      end else if (m_path % 2 == 0) begin
        // Settle occupies cycles 2..S+1; capture happens in cycle S+2.
        if (m_cyc == S + 2) begin
          e_out = (m_path == 0) ? r2r_raw : pwm_raw;
          e_mode = 2'(m_path);
          e_valid = 1'b1;
          m_cyc = 0;
        end else begin
          m_cyc++;
        end
      end else begin
        // Cycle 2 is the start pulse; done is honoured in cycles 3..T+2.
        if (m_got) begin
          e_out = m_val;
          e_mode = 2'(m_path);
          e_valid = 1'b1;
          m_cyc = 0;
        end else if (m_cyc >= 3 && ((m_path == 1) ? r2r_sar_done : pwm_sar_done)) begin
          m_got = 1'b1;
          m_val = (m_path == 1) ? r2r_sar_value : pwm_sar_value;
          m_cyc++;
        end else if (m_cyc == T + 2) begin
          e_err = 1'b1;
          m_cyc = 0;
        end else begin
          m_cyc++;
        end
      end
      e_busy = (m_cyc != 0);
    end
  end

  always @(posedge clk) begin
    #1;
    if (live) begin
      chk("busy", 8'(busy), 8'(e_busy));
      chk("active_mode", 8'(active_mode), 8'(e_active));
      chk("r2r_sar_start", 8'(r2r_sar_start), 8'(e_r2r_start));
      chk("pwm_sar_start", 8'(pwm_sar_start), 8'(e_pwm_start));
      chk("sample_valid", 8'(sample_valid), 8'(e_valid));
      chk("timeout_err", 8'(timeout_err), 8'(e_err));
      chk("sample_out", sample_out, e_out);
      chk("sample_mode", 8'(sample_mode), 8'(e_mode));
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  // which: 0 valid, 1 timeout_err, 2 r2r start, 3 pwm start. Returns at edge+2.
  task automatic wait_ev(input int which, input int max, input string nm, output int at);
    logic hit;
    at = -1;
    for (int n = 0; n < max; n++) begin
      @(posedge clk);
      #1;
      case (which)
        0:       hit = sample_valid;
        1:       hit = timeout_err;
        2:       hit = r2r_sar_start;
        default: hit = pwm_sar_start;
      endcase
      if (hit === 1'b1) begin
        at = cyc;
        break;
      end
    end
    #1;
    if (at < 0) begin
      errors++;
      $display("FAIL %s: no event within %0d cycles (got none, required one)", nm, max);
    end
  endtask

  // Wait for the path's start, then pulse its done k cycles later.
  task automatic respond(input int path, input int k, input logic [7:0] v, input bit spur,
                         output int at_start);
    wait_ev(path == 1 ? 2 : 3, 40, "start_seen", at_start);
    for (int j = 1; j <= k; j++) begin
      @(posedge clk);
      #2;
      if (path == 1) begin
        pwm_sar_done = spur && (j == 1);
        pwm_sar_value = 8'hFF;
        r2r_sar_done = (j == k);
        r2r_sar_value = v;
      end else begin
        r2r_sar_done = spur && (j == 1);
        r2r_sar_value = 8'hFF;
        pwm_sar_done = (j == k);
        pwm_sar_value = v;
      end
    end
    step(1);
    r2r_sar_done = 1'b0;
    pwm_sar_done = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish (got timeout, required completion)");
    $fatal(1);
  end

  initial begin
    int at;
    // Regular round-robin over paths 0 and 2.
    reset = 1'b1;
    auto_mode = 1'b1;
    mode_enable = 4'b0101;
    r2r_raw = 8'h3C;
    pwm_raw = 8'hA5;
    step(3);
    chk("reset_sample_out", sample_out, 8'h00);
    chk("reset_busy", 8'(busy), 8'h00);
    reset = 1'b0;
    wait_ev(0, 40, "valid_r2r_reg", at);
    chki("valid_r2r_reg_cycle", at, 19);
    chk("r2r_reg_value", sample_out, 8'h3C);
    chk("r2r_reg_mode", 8'(sample_mode), 8'd0);
    wait_ev(0, 40, "valid_pwm_reg", at);
    chki("valid_pwm_reg_cycle", at, 38);
    chk("pwm_reg_value", sample_out, 8'hA5);
    chk("pwm_reg_mode", 8'(sample_mode), 8'd2);
    wait_ev(0, 40, "valid_r2r_again", at);
    chki("valid_r2r_again_cycle", at, 57);

    // R2R successive with done 9 cycles after start.
    reset = 1'b1;
    mode_enable = 4'b0010;
    step(2);
    reset = 1'b0;
    respond(1, 9, 8'h7E, 1'b0, at);
    chki("r2r_start_cycle", at, 2);
    wait_ev(0, 10, "valid_r2r_sar", at);
    chki("valid_r2r_sar_cycle", at, 13);
    chk("r2r_sar_value", sample_out, 8'h7E);
    chk("r2r_sar_mode", 8'(sample_mode), 8'd1);

    // PWM successive timeout, then done on the final allowed cycle.
    mode_enable = 4'b1000;
    wait_ev(1, 40, "timeout_err", at);
    chki("timeout_cycle", at, 26);
    chk("timeout_keeps_out", sample_out, 8'h7E);
    chk("timeout_keeps_mode", 8'(sample_mode), 8'd1);
    respond(3, T, 8'h5A, 1'b0, at);
    chki("pwm_restart_cycle", at, 28);
    wait_ev(0, 10, "valid_pwm_sar_last", at);
    chki("valid_pwm_sar_last_cycle", at, 40);
    chk("pwm_sar_last_value", sample_out, 8'h5A);
    chk("pwm_sar_last_mode", 8'(sample_mode), 8'd3);

    // Manual with a disabled selection, then enabled with a spurious pwm done.
    auto_mode = 1'b0;
    manual_mode = 2'd1;
    mode_enable = 4'b0001;
    step(20);
    mode_enable = 4'b0010;
    respond(1, 3, 8'h11, 1'b1, at);
    wait_ev(0, 10, "valid_manual", at);
    chk("manual_value", sample_out, 8'h11);
    chk("manual_mode", 8'(sample_mode), 8'd1);

    // Reset during WAIT_DONE coinciding with done.
    auto_mode = 1'b1;
    wait_ev(2, 40, "start_before_reset", at);
    step(4);
    r2r_sar_done = 1'b1;
    r2r_sar_value = 8'hEE;
    reset = 1'b1;
    mode_enable = 4'b1111;
    step(1);
    r2r_sar_done = 1'b0;
    reset = 1'b0;
    chk("abort_sample_out", sample_out, 8'h00);
    chk("abort_busy", 8'(busy), 8'h00);
    chk("abort_valid", 8'(sample_valid), 8'h00);
    wait_ev(0, 40, "valid_after_reset", at);
    chki("valid_after_reset_cycle", at, 19);
    chk("after_reset_mode", 8'(sample_mode), 8'd0);
    chk("after_reset_value", sample_out, 8'h3C);

    step(2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
